spram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that owns one spram instance as its storage.

---
 rtl/spram_pkg.sv | 26 ++
 rtl/spram_fifo_obuf.sv | 47 ++++
 rtl/spram_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_spram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared constants for the spram-backed FIFO controller: read latency,
// output buffer depth, derived counter widths and the RAM port operation type.
package spram_pkg;

  localparam int RD_LATENCY = 2;
  localparam int OBUF_DEPTH = 3;
  // vld_pipe[STAGES:0] carries one bit per outstanding read cycle
  localparam int STAGES     = RD_LATENCY - 1;
  localparam int IDX_W      = $clog2(OBUF_DEPTH);
  localparam int OCC_W      = $clog2(OBUF_DEPTH + 1);
  localparam int INFL_W     = $clog2(RD_LATENCY + 1);
  // wide enough to hold occ + inflight without overflow
  localparam int CRED_W     = ((OCC_W > INFL_W) ? OCC_W : INFL_W) + 1;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_WRITE = 2'd1,
    PORT_READ  = 2'd2
  } port_op_e;

  // Output buffer slot index, wraps at OBUF_DEPTH-1
  function automatic logic [IDX_W-1:0] obuf_idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(OBUF_DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/spram_fifo_obuf.sv
// Small register FIFO holding words returned from the RAM; head is the
// FIFO output word. The parent's credit check keeps pushes from overflowing it.
module spram_fifo_obuf
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occ
);

  logic [OBUF_DEPTH-1:0][DATA_WIDTH-1:0] ent;
  logic [IDX_W-1:0]                      wr_idx;
  logic [IDX_W-1:0]                      rd_idx;
  logic                                  pop_ok;

  assign pop_ok = pop && (occ != '0);
  assign head   = ent[rd_idx];

  // Entry storage; contents need no reset since occ gates their use
  always_ff @(posedge clk) begin
    if (push) ent[wr_idx] <= push_data;
  end

  // Slot pointers and occupancy; simultaneous push and pop keeps occ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_idx <= obuf_idx_inc(wr_idx);
      if (pop_ok) rd_idx <= obuf_idx_inc(rd_idx);
      case ({push, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller owning one external single-port RAM. The RAM port does one
// write, one prefetch read or nothing each clock; read data returns two clocks
// later into a 3-entry output buffer so a sustained pop runs at full rate.
module spram_fifo_ctrl
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  init_done;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [STAGES:0]       vld_pipe;
  logic [INFL_W-1:0]     inflight;
  logic [OCC_W-1:0]      occ;
  logic [CRED_W-1:0]     credit_used;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  read_prio;
  logic                  do_wr;
  logic                  do_rd;
  port_op_e              port_op;
  logic                  obuf_pop;

  // Reads currently travelling through the RAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + INFL_W'(vld_pipe[i]);
  end

  assign credit_used = CRED_W'(occ) + CRED_W'(inflight);
  assign ram_empty   = (ram_cnt == '0);
  assign ram_full    = (ram_cnt == (ADDR_WIDTH+1)'(DEPTH));
  // Refill an empty output path ahead of pushes so pops never starve
  assign read_prio   = !ram_empty && (credit_used == '0);
  assign in_ready    = init_done && !ram_full && !read_prio;

  // RAM port arbitration: writes first unless read_prio blocked in_ready;
  // reads only issue when the output buffer has a free credit
  always_comb begin
    port_op = PORT_IDLE;
    if (in_valid && in_ready)
      port_op = PORT_WRITE;
    else if (!ram_empty && (credit_used < CRED_W'(OBUF_DEPTH)))
      port_op = PORT_READ;
  end

  assign do_wr     = (port_op == PORT_WRITE);
  assign do_rd     = (port_op == PORT_READ);
  assign mem_we    = do_wr;
  assign mem_addr  = do_wr ? wr_ptr : rd_ptr;
  assign mem_wdata = in_data;

  // Holds in_ready low for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // RAM pointers and occupancy; write and read are mutually exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        ram_cnt <= ram_cnt + 1'b1;
      end else if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        ram_cnt <= ram_cnt - 1'b1;
      end
    end
  end

  // Read-valid shift pipe; reset drops anything still inside the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], do_rd};
  end

  assign obuf_pop = out_valid && out_ready;

  spram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe[STAGES]),
    .push_data (mem_rdata),
    .pop       (obuf_pop),
    .head      (out_data),
    .occ       (occ)
  );

  assign out_valid = (occ != '0);
  assign count     = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(inflight)
                   + (ADDR_WIDTH+2)'(occ);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl with a 16-word, 2-clock-latency RAM model.
module tb_spram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  spram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: write on the edge, read data two edges later; pipe never reset
  logic [DW-1:0] ram [16];
  logic [DW-1:0] rs1, rs2;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rs1 <= ram[mem_addr];
    rs2 <= rs1;
  end
  assign mem_rdata = rs2;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] sb [$];
  logic [AW-1:0] exp_wp = '0;
  int            cyc_n = 0;
  logic          acc;
  int            first_ov = -1;

  // One clock: drive, check handshakes at negedge, check count after the edge
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    total++;
    if (mem_we !== acc) begin
      bad++; $display("FAIL mem_we cyc=%0d got=%b want=%b", cyc_n, mem_we, acc);
    end
    if (out_valid === 1'b1 && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL pop_empty cyc=%0d got=%h want=none", cyc_n, out_data);
      end else begin
        if (out_data !== sb[0]) begin
          bad++; $display("FAIL pop_data cyc=%0d got=%h want=%h", cyc_n, out_data, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    if (acc) begin
      total++;
      if (mem_addr !== exp_wp || mem_wdata !== id) begin
        bad++; $display("FAIL wr_port cyc=%0d got=%h/%h want=%h/%h",
                        cyc_n, mem_addr, mem_wdata, exp_wp, id);
      end
      sb.push_back(id);
      exp_wp = exp_wp + 1'b1;
    end
    if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc_n;
    @(posedge clk); #1;
    cyc_n++;
    total++;
    if (count !== (AW+2)'(sb.size())) begin
      bad++; $display("FAIL count cyc=%0d got=%0d want=%0d", cyc_n, count, sb.size());
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic ordy);
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 30) begin
      cyc(1'b1, d, ordy);
      n++;
    end
    total++;
    if (!acc) begin bad++; $display("FAIL push_timeout got=stuck want=accept data=%h", d); end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL drain got=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 5;
    if (count !== '0)     begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    if (out_valid !== 0)  begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 0)   begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    if (mem_we !== 0)     begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    if (mem_addr !== '0)  begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 0) begin bad++; $display("FAIL rel_in_ready0 got=%b want=0", in_ready); end
    @(posedge clk); #1;
    total += 2;
    if (in_ready !== 1) begin bad++; $display("FAIL rel_in_ready1 got=%b want=1", in_ready); end
    if (count !== '0)   begin bad++; $display("FAIL rel_count got=%0d want=0", count); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    int k;
    first_ov = -1;
    push_word(8'h01, 1'b0);
    k = cyc_n - 1;
    for (int i = 2; i <= 5; i++) push_word(DW'(i), 1'b0);
    drain();
    total += 2;
    if (first_ov != k + 4) begin
      bad++; $display("FAIL first_latency got=%0d want=%0d", first_ov - k - 1, 3);
    end
    if (count !== '0) begin bad++; $display("FAIL basic_count got=%0d want=0", count); end
  endtask

  task automatic test_full();
    logic seen = 1'b0;
    for (int i = 0; i < 19; i++) push_word(DW'(8'h20 + i), 1'b0);
    total += 2;
    if (in_ready !== 0)     begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    if (count !== 6'd19)    begin bad++; $display("FAIL full_count got=%0d want=19", count); end
    repeat (2) begin
      cyc(1'b1, 8'hEE, 1'b0);
      total++;
      if (acc) begin bad++; $display("FAIL full_accept got=1 want=0"); end
    end
    cyc(1'b0, '0, 1'b1);
    total++;
    if (sb.size() != 18) begin bad++; $display("FAIL full_pop got=%0d want=18", sb.size()); end
    repeat (3) begin
      if (in_ready === 1'b1) seen = 1'b1;
      cyc(1'b0, '0, 1'b0);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL full_reopen got=0 want=1"); end
    drain();
  endtask

  task automatic test_stream();
    int pat = 0, lowrun = 0, maxlow = 0;
    repeat (200) begin
      cyc(1'b1, DW'(pat), 1'b1);
      if (acc) begin pat++; lowrun = 0; end
      else begin lowrun++; if (lowrun > maxlow) maxlow = lowrun; end
    end
    total += 2;
    if (maxlow > 6) begin bad++; $display("FAIL stream_stall got=%0d want<=6", maxlow); end
    if (pat < 50)   begin bad++; $display("FAIL stream_rate got=%0d want>=50", pat); end
    drain();
  endtask

  task automatic test_reset_inflight();
    push_word(8'h55, 1'b0);
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    total += 2;
    if (out_valid !== 0) begin bad++; $display("FAIL rst2_out_valid got=%b want=0", out_valid); end
    if (count !== '0)    begin bad++; $display("FAIL rst2_count got=%0d want=0", count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_wp = '0;
    @(posedge clk); #1;
    repeat (5) begin
      cyc(1'b0, '0, 1'b0);
      total++;
      if (out_valid !== 0) begin bad++; $display("FAIL stale_enq got=%b want=0", out_valid); end
    end
  endtask

  task automatic test_random();
    repeat (600) cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
